er_dma_arbiter: RTL

Arbitrates two DMA requesters for the shared memory bus and holds off DMA while the CPU program counter is inside the protected executable region (ER). Holding off DMA keeps ER execution from being aborted by the execution monitor. The block also owns the ER bounds registers, with a write-once lock, and drives the `dma_en` signal consumed by the execution monitor. A bounded wait guarantees DMA forward progress: a forced grant is flagged so software can tell that an ER run was sacrificed.

---
 rtl/asap_pkg.sv | 29 ++
 rtl/er_bounds_reg.sv | 50 +++++
 rtl/er_dma_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/asap_pkg.sv
// Shared definitions for ER-aware DMA blocks.
// Provides the arbiter FSM state encoding, the ER bounds reset values,
// the default hold-off budget, and the two-requester round-robin pick.
package asap_pkg;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned MAX_WAIT_DEF = 64;

  // Reset window is empty (min > max), so nothing is inside the ER.
  localparam logic [ADDR_W-1:0] ER_MIN_RST = 16'hFFFF;
  localparam logic [ADDR_W-1:0] ER_MAX_RST = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GRANT = 2'd2
  } arb_state_e;

  // One-hot winner: the sole requester, or the one that was not last.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] pick;
    pick = req;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
    return pick;
  endfunction

endpackage

// File: rtl/er_bounds_reg.sv
// ER bounds registers with a write-once lock and the in-ER compare.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   pc                   CPU program counter
//   cfg_we, cfg_sel      bounds write strobe / target (0 = min, 1 = max)
//   cfg_wdata            bounds write data
//   cfg_lock             sets locked (cleared only by reset)
//   er_min, er_max       inclusive ER bounds
//   locked               bounds are write-protected
//   in_er_c              combinational: pc inside [er_min, er_max]
module er_bounds_reg
  import asap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  input  logic              cfg_lock,
  output logic [ADDR_W-1:0] er_min,
  output logic [ADDR_W-1:0] er_max,
  output logic              locked,
  output logic              in_er_c
);

  // Bounds and lock; a write in the locking cycle still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      er_min <= ER_MIN_RST;
      er_max <= ER_MAX_RST;
      locked <= 1'b0;
    end else begin
      if (cfg_we && !locked) begin
        if (cfg_sel) begin
          er_max <= cfg_wdata;
        end else begin
          er_min <= cfg_wdata;
        end
      end
      if (cfg_lock) begin
        locked <= 1'b1;
      end
    end
  end

  // An inverted window (min > max) can never satisfy both terms.
  assign in_er_c = (pc >= er_min) && (pc <= er_max);

endmodule

// File: rtl/er_dma_arbiter.sv
// Two-requester DMA arbiter that holds off DMA while the CPU executes
// inside the protected ER, with a bounded wait that forces a grant.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   pc                       CPU program counter
//   cfg_we/cfg_sel/cfg_wdata ER bounds write port
//   cfg_lock                 write-protect the bounds until reset
//   req                      level DMA requests, held until served
//   gnt                      one-hot registered grant
//   dma_en                   OR of gnt, to the execution monitor
//   er_min, er_max           ER bounds (inclusive)
//   locked                   bounds are write-protected
//   forced                   one-cycle pulse: grant issued by timeout in ER
module er_dma_arbiter
  import asap_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned CW       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [15:0] cfg_wdata,
  input  logic        cfg_lock,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic        dma_en,
  output logic [15:0] er_min,
  output logic [15:0] er_max,
  output logic        locked,
  output logic        forced
);

  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [1:0]    gnt_d;
  logic          dma_en_d;
  logic          forced_d;
  logic          in_er_c;
  logic          timeout_c;

  er_bounds_reg u_bounds (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .cfg_lock  (cfg_lock),
    .er_min    (er_min),
    .er_max    (er_max),
    .locked    (locked),
    .in_er_c   (in_er_c)
  );

  assign timeout_c = (cnt_q == WAIT_LAST);

  // State, counter, round-robin history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt     <= 2'b00;
      dma_en  <= 1'b0;
      forced  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt     <= gnt_d;
      dma_en  <= dma_en_d;
      forced  <= forced_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt;
    forced_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          if (in_er_c) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            state_d = ST_GRANT;
            gnt_d   = rr_pick(req, last_q);
          end
        end
      end

      ST_HOLD: begin
        if (!(|req)) begin
          state_d = ST_IDLE;
        end else if (!in_er_c || timeout_c) begin
          // Winner is picked now, from whatever is pending at grant time.
          state_d  = ST_GRANT;
          gnt_d    = rr_pick(req, last_q);
          forced_d = in_er_c;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_GRANT: begin
        // No preemption: only the owner dropping its request ends the grant.
        if (!(|(req & gnt))) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          last_d  = gnt[1];
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    dma_en_d = |gnt_d;
  end

endmodule
